// File: rtl/hazard_pkg.sv
// Shared types and constants for the ID-stage hazard scoreboard.
package hazard_pkg;

    // Why ID is being held. Priority when several apply: SERIAL > BRANCH > DATA.
    typedef enum logic [1:0] {
        STALL_NONE   = 2'd0,
        STALL_DATA   = 2'd1,
        STALL_BRANCH = 2'd2,
        STALL_SERIAL = 2'd3
    } stall_cause_t;

    // Result latencies of the common producers, in cycles from issue to forwardable.
    localparam int ALU_LAT  = 1;
    localparam int LOAD_LAT = 2;

    // Register-number width for a register file of nreg entries.
    function automatic int reg_w(input int nreg);
        return (nreg > 1) ? $clog2(nreg) : 1;
    endfunction

endpackage

// File: rtl/fetch_cancel_tracker.sv
// Counts in-flight instruction-fetch requests and marks responses that belong
// to requests issued before a redirect or flush, so IF can discard them.
module fetch_cancel_tracker #(
    parameter int MAX_OUTST = 2
) (
    input  logic                           aclk,
    input  logic                           reset,
    input  logic                           br_redirect,
    input  logic                           pipe_flush,
    input  logic                           if_req_fire,
    input  logic                           if_resp_fire,
    output logic                           if_req_ready,
    output logic                           if_resp_drop,
    output logic [$clog2(MAX_OUTST+1)-1:0] outst_cnt
);

    localparam int OUT_W = $clog2(MAX_OUTST + 1);
    // A request may be accepted in the same cycle a full queue returns a
    // response, so the stale count can reach MAX_OUTST+1.
    localparam int CAN_W = $clog2(MAX_OUTST + 2);

    logic [OUT_W-1:0] outst_reg, outst_next;
    logic [CAN_W-1:0] cancel_reg, cancel_next;
    logic             redirect;

    assign redirect     = br_redirect || pipe_flush;
    assign if_resp_drop = if_resp_fire && (cancel_reg != '0);
    assign if_req_ready = (outst_reg < OUT_W'(MAX_OUTST)) || if_resp_fire;
    assign outst_cnt    = outst_reg;

    // In-flight count follows the request/response handshakes only.
    always_comb begin
        outst_next = outst_reg + OUT_W'(if_req_fire) - OUT_W'(if_resp_fire);
    end

    // A redirect reloads the stale count from everything still in flight,
    // including a request accepted in the redirect cycle itself.
    always_comb begin
        cancel_next = cancel_reg;
        if (redirect) begin
            cancel_next = CAN_W'(outst_reg)
                        - CAN_W'(if_resp_fire && (cancel_reg == '0))
                        + CAN_W'(if_req_fire);
        end else if (if_resp_drop) begin
            cancel_next = cancel_reg - CAN_W'(1);
        end
    end

    // Counter registers.
    always_ff @(posedge aclk) begin
        if (reset) begin
            outst_reg  <= '0;
            cancel_reg <= '0;
        end else begin
            outst_reg  <= outst_next;
            cancel_reg <= cancel_next;
        end
    end

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// ID-stage hazard unit: a per-register countdown scoreboard gives load-use,
// branch-in-ID and serialisation stalls from one rule; fetch tracking drops
// stale IF responses after a redirect or flush.
module hazard_scoreboard_unit
    import hazard_pkg::*;
#(
    parameter int NREG      = 32,
    parameter int NSRC      = 3,
    parameter int MAX_LAT   = 4,
    parameter int SER_LAT   = 3,
    parameter int MAX_OUTST = 2
) (
    input  logic                            aclk,
    input  logic                            reset,
    input  logic                            id_valid,
    input  logic [NSRC*$clog2(NREG)-1:0]    id_src_no,
    input  logic [NSRC-1:0]                 id_src_used,
    input  logic                            id_is_branch,
    input  logic                            id_is_serial,
    input  logic                            id_dst_we,
    input  logic [$clog2(NREG)-1:0]         id_dst_no,
    input  logic [$clog2(MAX_LAT+1)-1:0]    id_res_lat,
    input  logic                            id_fire,
    input  logic                            pipe_flush,
    input  logic                            br_redirect,
    input  logic                            if_req_fire,
    input  logic                            if_resp_fire,
    output logic                            id_stall,
    output logic [1:0]                      stall_cause,
    output logic                            if_req_ready,
    output logic                            if_resp_drop,
    output logic [$clog2(MAX_OUTST+1)-1:0]  outst_cnt
);

    localparam int REG_W = reg_w(NREG);
    localparam int CNT_W = $clog2(MAX_LAT + 1);
    localparam int SER_W = $clog2(SER_LAT + 1);

    logic                    set_dst;
    logic [NREG*CNT_W-1:0]   cnt_flat;
    logic [NSRC-1:0]         data_hit;
    logic [NSRC-1:0]         br_hit;
    logic [SER_W-1:0]        ser_cnt_reg, ser_cnt_next;
    stall_cause_t            cause_sel;

    assign set_dst = id_fire && id_dst_we && (id_dst_no != '0);

    // r0 is hard-wired and never produces a hazard.
    assign cnt_flat[CNT_W-1:0] = '0;

    genvar gi;

    // One countdown per architectural register: cycles until it is forwardable.
    generate
        for (gi = 1; gi < NREG; gi++) begin : g_sb
            logic [CNT_W-1:0] cnt_reg, cnt_next;

            // Flush wins over a same-cycle writer; a writer wins over the countdown.
            always_comb begin
                cnt_next = cnt_reg;
                if (pipe_flush) begin
                    cnt_next = '0;
                end else if (set_dst && (id_dst_no == REG_W'(gi))) begin
                    cnt_next = id_res_lat;
                end else if (cnt_reg != '0) begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end

            // Scoreboard entry register.
            always_ff @(posedge aclk) begin
                if (reset) begin
                    cnt_reg <= '0;
                end else begin
                    cnt_reg <= cnt_next;
                end
            end

            assign cnt_flat[gi*CNT_W +: CNT_W] = cnt_reg;
        end
    endgenerate

    // Per-operand check: a branch compares in ID so it needs the value one
    // cycle earlier than an EX consumer, hence the lower threshold.
    generate
        for (gi = 0; gi < NSRC; gi++) begin : g_src
            logic [REG_W-1:0] src_no;
            logic [CNT_W-1:0] src_cnt;
            logic             src_live;

            assign src_no       = id_src_no[gi*REG_W +: REG_W];
            assign src_cnt      = cnt_flat[src_no*CNT_W +: CNT_W];
            assign src_live     = id_src_used[gi] && (src_no != '0);
            assign br_hit[gi]   = src_live && id_is_branch  && (src_cnt >= CNT_W'(1));
            assign data_hit[gi] = src_live && !id_is_branch && (src_cnt >= CNT_W'(2));
        end
    endgenerate

    // Serialisation window: ID stays blocked for SER_LAT cycles after a CSR issues.
    always_comb begin
        ser_cnt_next = ser_cnt_reg;
        if (pipe_flush) begin
            ser_cnt_next = '0;
        end else if (id_fire && id_is_serial) begin
            ser_cnt_next = SER_W'(SER_LAT);
        end else if (ser_cnt_reg != '0) begin
            ser_cnt_next = ser_cnt_reg - SER_W'(1);
        end
    end

    // Serial counter register.
    always_ff @(posedge aclk) begin
        if (reset) begin
            ser_cnt_reg <= '0;
        end else begin
            ser_cnt_reg <= ser_cnt_next;
        end
    end

    // Stall decision with cause priority; the flush cycle never stalls.
    always_comb begin
        cause_sel = STALL_NONE;
        if (id_valid && !pipe_flush) begin
            if (ser_cnt_reg != '0) begin
                cause_sel = STALL_SERIAL;
            end else if (|br_hit) begin
                cause_sel = STALL_BRANCH;
            end else if (|data_hit) begin
                cause_sel = STALL_DATA;
            end
        end
    end

    assign stall_cause = cause_sel;
    assign id_stall    = (cause_sel != STALL_NONE);

    fetch_cancel_tracker #(
        .MAX_OUTST (MAX_OUTST)
    ) u_fetch_cancel_tracker (
        .aclk         (aclk),
        .reset        (reset),
        .br_redirect  (br_redirect),
        .pipe_flush   (pipe_flush),
        .if_req_fire  (if_req_fire),
        .if_resp_fire (if_resp_fire),
        .if_req_ready (if_req_ready),
        .if_resp_drop (if_resp_drop),
        .outst_cnt    (outst_cnt)
    );

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Self-checking bench for hazard_scoreboard_unit: directed hazard/fetch steps
// followed by random traffic, all checked against a time-based reference model.
module tb_hazard_scoreboard_unit;
    import hazard_pkg::*;

    localparam int NREG      = 32;
    localparam int NSRC      = 3;
    localparam int MAX_LAT   = 4;
    localparam int SER_LAT   = 3;
    localparam int MAX_OUTST = 2;
    localparam int REG_W     = $clog2(NREG);
    localparam int LAT_W     = $clog2(MAX_LAT + 1);
    localparam int OUT_W     = $clog2(MAX_OUTST + 1);

    logic                    aclk = 1'b0;
    logic                    reset;
    logic                    id_valid;
    logic [NSRC*REG_W-1:0]   id_src_no;
    logic [NSRC-1:0]         id_src_used;
    logic                    id_is_branch;
    logic                    id_is_serial;
    logic                    id_dst_we;
    logic [REG_W-1:0]        id_dst_no;
    logic [LAT_W-1:0]        id_res_lat;
    logic                    id_fire;
    logic                    pipe_flush;
    logic                    br_redirect;
    logic                    if_req_fire;
    logic                    if_resp_fire;
    logic                    id_stall;
    logic [1:0]              stall_cause;
    logic                    if_req_ready;
    logic                    if_resp_drop;
    logic [OUT_W-1:0]        outst_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: absolute cycle at which each register becomes
    // forwardable, end of the serial window, and per-request stale flags.
    int now = 0;
    int done_at [NREG];
    int ser_done = 0;
    bit stale_q [$];

    always #5 aclk = ~aclk;

    hazard_scoreboard_unit #(
        .NREG(NREG), .NSRC(NSRC), .MAX_LAT(MAX_LAT), .SER_LAT(SER_LAT), .MAX_OUTST(MAX_OUTST)
    ) dut (
        .aclk(aclk), .reset(reset), .id_valid(id_valid), .id_src_no(id_src_no),
        .id_src_used(id_src_used), .id_is_branch(id_is_branch), .id_is_serial(id_is_serial),
        .id_dst_we(id_dst_we), .id_dst_no(id_dst_no), .id_res_lat(id_res_lat), .id_fire(id_fire),
        .pipe_flush(pipe_flush), .br_redirect(br_redirect), .if_req_fire(if_req_fire),
        .if_resp_fire(if_resp_fire), .id_stall(id_stall), .stall_cause(stall_cause),
        .if_req_ready(if_req_ready), .if_resp_drop(if_resp_drop), .outst_cnt(outst_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: got=%0h expected=%0h cycle=%0d", tag, got, exp, now);
        end
    endtask

    // Expected cause from remaining cycles until each source is forwardable.
    function automatic stall_cause_t model_cause();
        bit ser_h, br_h, data_h;
        int r, rem;
        ser_h  = (ser_done > now);
        br_h   = 1'b0;
        data_h = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            r   = int'(id_src_no[i*REG_W +: REG_W]);
            rem = done_at[r] - now;
            if (rem < 0) rem = 0;
            if (id_src_used[i] && r != 0) begin
                if (id_is_branch && rem >= 1) br_h = 1'b1;
                if (!id_is_branch && rem >= 2) data_h = 1'b1;
            end
        end
        if (!id_valid || pipe_flush) return STALL_NONE;
        if (ser_h) return STALL_SERIAL;
        if (br_h) return STALL_BRANCH;
        if (data_h) return STALL_DATA;
        return STALL_NONE;
    endfunction

    task automatic check_outputs();
        stall_cause_t ec;
        bit exp_drop;
        ec = model_cause();
        exp_drop = if_resp_fire && (stale_q.size() > 0) && stale_q[0];
        chk("id_stall", id_stall, ec != STALL_NONE);
        chk("stall_cause", stall_cause, ec);
        chk("if_req_ready", if_req_ready, (stale_q.size() < MAX_OUTST) || if_resp_fire);
        chk("if_resp_drop", if_resp_drop, exp_drop);
        chk("outst_cnt", outst_cnt, stale_q.size());
        n_checks++;
        assert (!(id_fire && id_stall)) else begin
            n_errors++;
            $error("FAIL fire_while_stall: got=1 expected=0 cycle=%0d", now);
        end
    endtask

    task automatic model_tick();
        if (reset) begin
            foreach (done_at[r]) done_at[r] = 0;
            ser_done = 0;
            stale_q.delete();
        end else begin
            if (pipe_flush) begin
                foreach (done_at[r]) done_at[r] = 0;
                ser_done = 0;
            end else if (id_fire) begin
                if (id_dst_we && id_dst_no != 0) done_at[id_dst_no] = now + 1 + int'(id_res_lat);
                if (id_is_serial) ser_done = now + 1 + SER_LAT;
            end
            if (if_resp_fire && stale_q.size() > 0) void'(stale_q.pop_front());
            if (if_req_fire) stale_q.push_back(1'b0);
            if (br_redirect || pipe_flush) foreach (stale_q[k]) stale_q[k] = 1'b1;
        end
        now++;
    endtask

    // Inputs are already driven (after a negedge); check, then clock.
    task automatic run_cycle();
        #1;
        check_outputs();
        @(posedge aclk);
        model_tick();
        @(negedge aclk);
    endtask

    task automatic idle();
        id_valid = 0; id_src_no = '0; id_src_used = '0; id_is_branch = 0; id_is_serial = 0;
        id_dst_we = 0; id_dst_no = '0; id_res_lat = LAT_W'(1); id_fire = 0;
        pipe_flush = 0; br_redirect = 0; if_req_fire = 0; if_resp_fire = 0;
    endtask

    task automatic instr(input bit fire, input logic [REG_W-1:0] s0, input logic [REG_W-1:0] s1,
                         input logic [NSRC-1:0] used, input bit br, input bit ser,
                         input bit we, input logic [REG_W-1:0] dst, input int lat);
        id_valid = 1; id_fire = fire; id_src_no = {REG_W'(0), s1, s0}; id_src_used = used;
        id_is_branch = br; id_is_serial = ser; id_dst_we = we; id_dst_no = dst;
        id_res_lat = LAT_W'(lat);
    endtask

    initial begin
        reset = 1'b1;
        idle();
        @(posedge aclk);
        model_tick();
        @(negedge aclk);

        // Reset state (response strobe held to show nothing is dropped)
        if_resp_fire = 1;
        #1;
        chk("rst_stall", id_stall, 0);
        chk("rst_cause", stall_cause, STALL_NONE);
        chk("rst_ready", if_req_ready, 1);
        chk("rst_drop", if_resp_drop, 0);
        chk("rst_outst", outst_cnt, 0);
        run_cycle();
        reset = 0;
        idle();

        // ALU -> ALU: no bubble
        instr(1, 0, 0, 3'b000, 0, 0, 1, 5, ALU_LAT); run_cycle();
        instr(0, 5, 0, 3'b001, 0, 0, 0, 0, 1);
        #1 chk("alu_alu_nostall", id_stall, 0);
        id_fire = 1; run_cycle();

        // Load -> use: one bubble
        instr(1, 0, 0, 3'b000, 0, 0, 1, 5, LOAD_LAT); run_cycle();
        instr(0, 5, 0, 3'b001, 0, 0, 0, 0, 1);
        #1 chk("ld_use_stall", id_stall, 1);
        chk("ld_use_cause", stall_cause, STALL_DATA);
        run_cycle();
        #1 chk("ld_use_clear", id_stall, 0);
        id_fire = 1; run_cycle();

        // Load -> branch: two bubbles
        instr(1, 0, 0, 3'b000, 0, 0, 1, 7, LOAD_LAT); run_cycle();
        instr(0, 0, 7, 3'b010, 1, 0, 0, 0, 1);
        #1 chk("ld_br_stall1", id_stall, 1);
        chk("ld_br_cause", stall_cause, STALL_BRANCH);
        run_cycle();
        #1 chk("ld_br_stall2", id_stall, 1);
        run_cycle();
        #1 chk("ld_br_clear", id_stall, 0);
        id_fire = 1; run_cycle();

        // Branch reading r0 never stalls
        instr(1, 0, 0, 3'b000, 0, 0, 1, 7, LOAD_LAT); run_cycle();
        instr(0, 0, 0, 3'b010, 1, 0, 0, 0, 1);
        #1 chk("br_r0_nostall", id_stall, 0);
        id_fire = 1; run_cycle();
        idle(); run_cycle(); run_cycle(); run_cycle();

        // CSR serialisation, flushed in the second blocked cycle
        instr(1, 0, 0, 3'b000, 0, 1, 0, 0, 1); run_cycle();
        instr(0, 1, 0, 3'b001, 0, 0, 0, 0, 1);
        #1 chk("ser_stall1", id_stall, 1);
        chk("ser_cause", stall_cause, STALL_SERIAL);
        run_cycle();
        pipe_flush = 1;
        #1 chk("ser_flush_cycle", id_stall, 0);
        run_cycle();
        pipe_flush = 0;
        #1 chk("ser_after_flush", id_stall, 0);
        id_fire = 1; run_cycle();
        idle();

        // Two requests, redirect, both responses stale, third fresh
        if_req_fire = 1; run_cycle(); run_cycle();
        if_req_fire = 0; br_redirect = 1;
        #1 chk("full_ready", if_req_ready, 0);
        run_cycle();
        br_redirect = 0;
        #1 chk("redir_ready", if_req_ready, 0);
        run_cycle();
        if_resp_fire = 1;
        #1 chk("stale1_drop", if_resp_drop, 1);
        chk("resp_ready", if_req_ready, 1);
        run_cycle();
        #1 chk("stale2_drop", if_resp_drop, 1);
        run_cycle();
        if_resp_fire = 0; if_req_fire = 1; run_cycle();
        if_req_fire = 0; if_resp_fire = 1;
        #1 chk("fresh_nodrop", if_resp_drop, 0);
        run_cycle();
        if_resp_fire = 0;

        // Redirect with same-cycle response and request, one outstanding
        if_req_fire = 1; run_cycle();
        br_redirect = 1; if_resp_fire = 1;
        #1 chk("redir_resp_nodrop", if_resp_drop, 0);
        run_cycle();
        br_redirect = 0; if_req_fire = 0;
        #1 chk("redir_newreq_drop", if_resp_drop, 1);
        run_cycle();
        if_resp_fire = 0;
        #1 chk("outst_back_zero", outst_cnt, 0);
        run_cycle();

        // Mid-operation reset
        instr(1, 0, 0, 3'b000, 0, 0, 1, 9, MAX_LAT); if_req_fire = 1; run_cycle();
        instr(1, 0, 0, 3'b000, 0, 1, 0, 0, 1); br_redirect = 1; run_cycle();
        idle(); reset = 1; run_cycle();
        reset = 0;
        instr(0, 9, 0, 3'b001, 0, 0, 0, 0, 1);
        #1 chk("post_rst_nostall", id_stall, 0);
        chk("post_rst_outst", outst_cnt, 0);
        run_cycle();
        idle(); if_req_fire = 1; run_cycle();
        if_req_fire = 0; if_resp_fire = 1;
        #1 chk("post_rst_nodrop", if_resp_drop, 0);
        run_cycle();
        idle();

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            idle();
            pipe_flush   = ($urandom_range(0, 19) == 0);
            br_redirect  = ($urandom_range(0, 7) == 0);
            id_valid     = ($urandom_range(0, 3) != 0);
            id_src_no    = {REG_W'($urandom_range(0, 7)), REG_W'($urandom_range(0, 7)),
                            REG_W'($urandom_range(0, 7))};
            id_src_used  = NSRC'($urandom_range(0, 7));
            id_is_branch = ($urandom_range(0, 3) == 0);
            id_is_serial = ($urandom_range(0, 15) == 0);
            id_dst_we    = ($urandom_range(0, 1) == 1);
            id_dst_no    = REG_W'($urandom_range(0, 7));
            id_res_lat   = LAT_W'($urandom_range(1, MAX_LAT));
            if_resp_fire = (stale_q.size() > 0) && ($urandom_range(0, 1) == 1);
            if ((br_redirect || pipe_flush) && if_resp_fire && stale_q[0]) if_resp_fire = 0;
            if_req_fire  = ((stale_q.size() < MAX_OUTST) || if_resp_fire) && ($urandom_range(0, 1) == 1);
            id_fire      = id_valid && (model_cause() == STALL_NONE) && ($urandom_range(0, 3) != 0);
            run_cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
